spi_minion_stream: RTL and testbench

// - Parametrised SPI minion (peripheral) for the user-area interconnect: the successor to the fixed 1-bit-mode minion.
// - Bridges an external SPI host (cs/sclk/mosi/miso on GPIO) to internal val/rdy streams in the clk domain.
// - Adds: runtime CPOL/CPHA selection, configurable word width, a receive FIFO, sticky error flags and optional parity.

---
 rtl/spi_minion_stream.sv | 167 ++++++++++++++++
 tb/tb_spi_minion_stream.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_minion_stream.sv
// SPI minion bridging an external host to val/rdy streams, with runtime CPOL/CPHA and a receive FIFO.
// Optional parity of accepted words is enabled by defining SPI_MINION_PARITY_EN.
module spi_minion_stream #(
    parameter int NBITS = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic             cpol,
    input  logic             cpha,
    output logic [NBITS-1:0] recv_msg,
    output logic             recv_val,
    input  logic             recv_rdy,
    input  logic [NBITS-1:0] send_msg,
    input  logic             send_val,
    output logic             send_rdy,
    output logic             overflow,
    output logic             underflow,
    output logic             frame_err,
    input  logic             clr_status,
    output logic             parity
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NBITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(NBITS + 1);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [1:0] cs_sync, sclk_sync, mosi_sync;
    logic       cs_prev, sclk_prev;

    logic [0:0]       state;
    logic             cpol_q, cpha_q, lead_seen;
    logic [CW-1:0]    bit_cnt;
    logic [NBITS-1:0] shift_in, shift_out;

    logic [NBITS-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    // cs synchronises to 0 so a cs already low when reset releases is not seen as a new frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
            cs_sync   <= {cs_sync[0], cs};
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_prev   <= cs_sync[1];
            sclk_prev <= sclk_sync[1];
        end
    end

    logic cs_fall, cs_rise, lead, trail, sample_en, shift_en;
    logic frame_end, word_ok, full, pop, push;

    assign cs_fall   = cs_prev & ~cs_sync[1];
    assign cs_rise   = ~cs_prev & cs_sync[1];
    assign lead      = (state == ACTIVE) && (sclk_sync[1] != cpol_q) && (sclk_prev == cpol_q);
    assign trail     = (state == ACTIVE) && (sclk_sync[1] == cpol_q) && (sclk_prev != cpol_q);
    assign sample_en = cpha_q ? trail : lead;
    assign shift_en  = cpha_q ? (lead && lead_seen) : trail;

    assign send_rdy  = (state == IDLE) && cs_fall;
    assign frame_end = (state == ACTIVE) && cs_rise;
    assign word_ok   = frame_end && (bit_cnt == CNT_FULL);

    assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign recv_val  = (wr_ptr != rd_ptr);
    assign pop       = recv_val & recv_rdy;
    assign push      = word_ok & (~full | pop);
    assign recv_msg  = mem[rd_ptr[AW-1:0]];

    assign miso_oe   = (state == ACTIVE);
    assign miso      = (state == ACTIVE) & shift_out[NBITS-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lead_seen <= 1'b0;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        cpol_q    <= cpol;
                        cpha_q    <= cpha;
                        lead_seen <= 1'b0;
                        bit_cnt   <= '0;
                        shift_out <= send_val ? send_msg : '0;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end else begin
                        if (lead) lead_seen <= 1'b1;
                        // Bits past NBITS only advance the saturating counter; the frame is discarded anyway.
                        if (sample_en && bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt < CNT_FULL) shift_in <= {shift_in[NBITS-2:0], mosi_sync[1]};
                        end
                        if (shift_en) shift_out <= {shift_out[NBITS-2:0], 1'b0};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= shift_in;
    end

    // Set has priority over clear so an error in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (word_ok && full && !pop)          overflow  <= 1'b1;
            else if (clr_status)                  overflow  <= 1'b0;
            if (send_rdy && !send_val)            underflow <= 1'b1;
            else if (clr_status)                  underflow <= 1'b0;
            if (frame_end && bit_cnt != CNT_FULL) frame_err <= 1'b1;
            else if (clr_status)                  frame_err <= 1'b0;
        end
    end

`ifdef SPI_MINION_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    parity_q <= 1'b0;
        else if (push) parity_q <= ^shift_in;
    end
    assign parity = parity_q;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_spi_minion_stream.sv
// Self-checking bench for spi_minion_stream (NBITS=8, DEPTH=4): a behavioural SPI host drives frames
// and a queue-based model predicts FIFO contents, sticky flags and parity.
module tb_spi_minion_stream;
    localparam int NBITS = 8;
    localparam int DEPTH = 4;
    localparam int H     = 8;

    logic             clk = 1'b0;
    logic             reset, cs, sclk, mosi, miso, miso_oe, cpol, cpha;
    logic [NBITS-1:0] recv_msg, send_msg;
    logic             recv_val, recv_rdy, send_val, send_rdy;
    logic             overflow, underflow, frame_err, clr_status, parity;

    spi_minion_stream #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .cpol(cpol), .cpha(cpha), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy), .overflow(overflow),
        .underflow(underflow), .frame_err(frame_err), .clr_status(clr_status), .parity(parity)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_pulses = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0, m_udf = 1'b0, m_fe = 1'b0, m_par = 1'b0;

    always @(negedge clk) if (send_rdy === 1'b1) rdy_pulses++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hc();
        repeat (H) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, " underflow"}, 32'(underflow), 32'(m_udf));
        check({tag, " frame_err"}, 32'(frame_err), 32'(m_fe));
        check({tag, " recv_val"}, 32'(recv_val), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, " recv_msg"}, 32'(recv_msg), 32'(q[0]));
        check({tag, " parity"}, 32'(parity), 32'(m_par));
        check({tag, " miso_oe idle"}, 32'(miso_oe), 32'd0);
        check({tag, " miso idle"}, 32'(miso), 32'd0);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] exp;
        exp = q.pop_front();
        check({tag, " pop val"}, 32'(recv_val), 32'd1);
        check({tag, " pop msg"}, 32'(recv_msg), 32'(exp));
        recv_rdy = 1'b1;
        @(negedge clk);
        recv_rdy = 1'b0;
    endtask

    task automatic clear_flags();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0; m_fe = 1'b0;
        @(negedge clk);
    endtask

    // Host-side view: nclk full sclk periods, MSB first, reset pulse optionally after rst_after bits.
    task automatic run_frame(input logic m_cpol, input logic m_cpha, input logic [7:0] tx, input int nclk,
                             input logic sval, input logic [7:0] smsg, input int rst_after, input string tag);
        logic [7:0] rx;
        logic       bitv;
        int         p0;
        rx = 8'h00;
        p0 = rdy_pulses;
        send_msg = smsg; send_val = sval; cpol = m_cpol; cpha = m_cpha;
        sclk = m_cpol; mosi = 1'b0;
        hc();
        cs = 1'b0;
        hc();
        check({tag, " miso_oe active"}, 32'(miso_oe), 32'd1);
        cpol = 1'($urandom); cpha = 1'($urandom);
        for (int i = 0; i < nclk; i++) begin
            bitv = (i < 8) ? tx[7-i] : 1'b0;
            if (!m_cpha) begin
                mosi = bitv; hc();
                if (i < 8) rx[7-i] = miso;
                sclk = ~m_cpol; hc(); sclk = m_cpol;
            end else begin
                hc(); sclk = ~m_cpol; mosi = bitv; hc();
                if (i < 8) rx[7-i] = miso;
                sclk = m_cpol;
            end
            if (i + 1 == rst_after) begin
                reset = 1'b0;
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        end
        hc();
        cs = 1'b1;
        hc(); hc();
        check({tag, " send_rdy pulses"}, 32'(rdy_pulses - p0), 32'd1);
        if (!sval) m_udf = 1'b1;
        if (rst_after >= 0) begin
            q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_fe = 1'b0; m_par = 1'b0;
        end else if (nclk == NBITS) begin
            if (q.size() < DEPTH) begin
                q.push_back(tx);
`ifdef SPI_MINION_PARITY_EN
                m_par = ^tx;
`endif
            end else begin
                m_ovf = 1'b1;
            end
        end else begin
            m_fe = 1'b1;
        end
        if (rst_after < 0 && nclk >= NBITS) check({tag, " host rx"}, 32'(rx), 32'(sval ? smsg : 8'h00));
        check_state(tag);
    endtask

    initial begin
        logic [7:0] tx, sm;
        reset = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
        recv_rdy = 1'b0; send_msg = '0; send_val = 1'b0; clr_status = 1'b0;
        repeat (5) @(negedge clk);
        check("reset send_rdy", 32'(send_rdy), 32'd0);
        check_state("reset");
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_state("post reset");

        run_frame(1'b0, 1'b0, 8'hA5, 8, 1'b1, 8'h3C, -1, "basic");
        pop_one("basic");

        for (int m = 0; m < 4; m++) begin
            sm = 8'($urandom);
            run_frame(1'(m >> 1), 1'(m), 8'h81, 8, 1'b1, sm, -1, $sformatf("mode%0d", m));
            pop_one($sformatf("mode%0d", m));
        end

        for (int k = 0; k < 8; k++) begin
            tx = 8'($urandom); sm = 8'($urandom);
            run_frame(1'($urandom), 1'($urandom), tx, 8, 1'b1, sm, -1, $sformatf("rand%0d", k));
            if (k % 2 == 1) begin
                while (q.size() > 0) pop_one($sformatf("rand%0d", k));
            end
        end

        for (int k = 1; k <= 5; k++)
            run_frame(1'b0, 1'b0, 8'(k), 8, 1'b1, 8'($urandom), -1, $sformatf("fill%0d", k));
        pop_one("ovf");
        run_frame(1'b1, 1'b1, 8'h06, 8, 1'b1, 8'h55, -1, "after pop");
        clear_flags();
        check_state("ovf cleared");
        while (q.size() > 0) pop_one("drain");

        run_frame(1'b0, 1'b1, 8'h77, 8, 1'b0, 8'hFF, -1, "underflow");
        clear_flags();
        check_state("udf cleared");
        pop_one("underflow word");

        run_frame(1'b0, 1'b0, 8'h3A, 7, 1'b1, 8'h11, -1, "short7");
        clear_flags();
        check_state("fe cleared");
        run_frame(1'b1, 1'b0, 8'h3A, 9, 1'b1, 8'h22, -1, "long9");
        clear_flags();
        run_frame(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h33, -1, "empty");
        clear_flags();

        run_frame(1'b0, 1'b0, 8'hAB, 8, 1'b1, 8'h44, -1, "pre reset");
        run_frame(1'b0, 1'b0, 8'hF0, 8, 1'b0, 8'h00, 4, "reset mid");
        run_frame(1'b0, 1'b0, 8'h5A, 8, 1'b1, 8'hC3, -1, "after reset");
        pop_one("after reset");
        check_state("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
